// File: rtl/squash_ctrl_if.sv
// Squash controller bus: ROB/dcache status toward the sequencer, recovery controls back out.
// drain_timeout exists only when SQUASH_CTRL_TIMEOUT_EN is defined.
interface squash_ctrl_if #(
  parameter int SQ_CNT_W = 4
);
  logic                squash_in;
  logic [31:0]         squash_pc;
  logic                halt_in;
  logic [SQ_CNT_W-1:0] sq_pending;
  logic                dcache_busy;
  logic                flush_backend;
  logic                rat_restore;
  logic                stall_frontend;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                halted;
`ifdef SQUASH_CTRL_TIMEOUT_EN
  logic                drain_timeout;

  modport master (
    output squash_in, squash_pc, halt_in, sq_pending, dcache_busy,
    input  flush_backend, rat_restore, stall_frontend, redirect_valid,
           redirect_pc, halted, drain_timeout
  );

  modport slave (
    input  squash_in, squash_pc, halt_in, sq_pending, dcache_busy,
    output flush_backend, rat_restore, stall_frontend, redirect_valid,
           redirect_pc, halted, drain_timeout
  );
`else
  modport master (
    output squash_in, squash_pc, halt_in, sq_pending, dcache_busy,
    input  flush_backend, rat_restore, stall_frontend, redirect_valid,
           redirect_pc, halted
  );

  modport slave (
    input  squash_in, squash_pc, halt_in, sq_pending, dcache_busy,
    output flush_backend, rat_restore, stall_frontend, redirect_valid,
           redirect_pc, halted
  );
`endif
endinterface

// File: rtl/squash_ctrl.sv
// Recovery sequencer: flush, store drain, RAT restore, fetch redirect; also parks the core on halt.
// Optional drain watchdog enabled by defining SQUASH_CTRL_TIMEOUT_EN.
module squash_ctrl #(
  parameter int SQ_CNT_W       = 4,
  parameter int RESTORE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clock,
  input logic         reset,
  squash_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FLUSH      = 3'd1;
  localparam logic [2:0] ST_DRAIN      = 3'd2;
  localparam logic [2:0] ST_RESTORE    = 3'd3;
  localparam logic [2:0] ST_REDIRECT   = 3'd4;
  localparam logic [2:0] ST_HALT_DRAIN = 3'd5;
  localparam logic [2:0] ST_HALTED     = 3'd6;

  localparam logic [SQ_CNT_W-1:0] SQ_EMPTY  = '0;
  localparam logic [3:0]          RCNT_LOAD = 4'(RESTORE_CYCLES - 1);

  if (RESTORE_CYCLES < 1 || RESTORE_CYCLES > 15) begin : g_bad_restore
    $error("squash_ctrl: RESTORE_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("squash_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] pc_q;
  logic [3:0]  rcnt;
  logic        drained;
  logic        drain_exit;
  logic        draining;

  assign drained  = (bus.sq_pending == SQ_EMPTY) && !bus.dcache_busy;
  assign draining = (state == ST_DRAIN) || (state == ST_HALT_DRAIN);

`ifdef SQUASH_CTRL_TIMEOUT_EN
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tcnt;
  logic       timeout_q;
  logic       expired;
  logic       drain_enter;

  assign expired     = (tcnt == TCNT_LAST);
  assign drain_exit  = drained || expired;
  assign drain_enter = (state == ST_FLUSH) ||
                       ((state == ST_IDLE) && !bus.squash_in && bus.halt_in);

  // Watchdog counts cycles spent draining; fires only if the drain itself has not completed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (drain_enter) begin
        tcnt <= 8'd0;
      end else if (draining && !expired) begin
        tcnt <= tcnt + 8'd1;
      end
      if (draining && expired && !drained) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.drain_timeout = timeout_q;
`else
  assign drain_exit = drained;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.squash_in) begin
          state_next = ST_FLUSH;
        end else if (bus.halt_in) begin
          state_next = ST_HALT_DRAIN;
        end
      end
      ST_FLUSH:      state_next = ST_DRAIN;
      ST_DRAIN:      if (drain_exit) state_next = ST_RESTORE;
      ST_RESTORE:    if (rcnt == 4'd0) state_next = ST_REDIRECT;
      ST_REDIRECT:   state_next = ST_IDLE;
      ST_HALT_DRAIN: if (drain_exit) state_next = ST_HALTED;
      ST_HALTED:     state_next = ST_HALTED;
      default:       state_next = ST_IDLE;
    endcase
  end

  // rcnt is reloaded on every DRAIN exit so each restore runs the full RESTORE_CYCLES.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pc_q  <= 32'd0;
      rcnt  <= 4'd0;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && bus.squash_in) begin
        pc_q <= bus.squash_pc;
      end
      if ((state == ST_DRAIN) && drain_exit) begin
        rcnt <= RCNT_LOAD;
      end else if ((state == ST_RESTORE) && (rcnt != 4'd0)) begin
        rcnt <= rcnt - 4'd1;
      end
    end
  end

  assign bus.flush_backend  = (state == ST_FLUSH);
  assign bus.rat_restore    = (state == ST_RESTORE);
  assign bus.stall_frontend = (state != ST_IDLE);
  assign bus.redirect_valid = (state == ST_REDIRECT);
  assign bus.redirect_pc    = pc_q;
  assign bus.halted         = (state == ST_HALTED);

endmodule

// File: tb/tb_squash_ctrl.sv
// Self-checking bench for squash_ctrl: directed scenarios plus randomized traffic against a cycle-count model.
// Watchdog checks are active when SQUASH_CTRL_TIMEOUT_EN is defined.
module tb_squash_ctrl;

  localparam int RC = 2;
`ifdef SQUASH_CTRL_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 0;
`endif

  localparam int MD_IDLE     = 0;
  localparam int MD_RECOVER  = 1;
  localparam int MD_HALTWAIT = 2;
  localparam int MD_PARKED   = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;

  squash_ctrl_if #(.SQ_CNT_W(4)) bus ();

  squash_ctrl #(
    .SQ_CNT_W(4),
    .RESTORE_CYCLES(RC),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Model: k is the cycle index since the triggering event, drain_end the cycle the drain finished.
  int          mode      = MD_IDLE;
  int          k         = 0;
  int          drain_end = 0;
  logic [31:0] m_pc      = 32'd0;
  bit          m_timeout = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mode = MD_IDLE; k = 0; drain_end = 0; m_pc = 32'd0; m_timeout = 1'b0;
    end else begin
      case (mode)
        MD_IDLE: begin
          if (bus.squash_in) begin
            mode = MD_RECOVER; k = 1; drain_end = 0; m_pc = bus.squash_pc;
          end else if (bus.halt_in) begin
            mode = MD_HALTWAIT; k = 1;
          end
        end
        MD_RECOVER: begin
          if (drain_end != 0 && k == drain_end + RC + 1) begin
            mode = MD_IDLE;
          end else begin
            if (drain_end == 0 && k >= 2) begin
              if (bus.sq_pending == 4'd0 && !bus.dcache_busy) begin
                drain_end = k;
              end else if (TO != 0 && k - 1 == TO) begin
                drain_end = k; m_timeout = 1'b1;
              end
            end
            k++;
          end
        end
        MD_HALTWAIT: begin
          if (bus.sq_pending == 4'd0 && !bus.dcache_busy) begin
            mode = MD_PARKED;
          end else if (TO != 0 && k == TO) begin
            mode = MD_PARKED; m_timeout = 1'b1;
          end else begin
            k++;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      bit recov;
      bit restored;
      recov    = (mode == MD_RECOVER);
      restored = recov && drain_end != 0;
      checkOutput("m_flush", 32'(bus.flush_backend), 32'(recov && k == 1));
      checkOutput("m_restore", 32'(bus.rat_restore),
                  32'(restored && k > drain_end && k <= drain_end + RC));
      checkOutput("m_redirect", 32'(bus.redirect_valid), 32'(restored && k == drain_end + RC + 1));
      checkOutput("m_stall", 32'(bus.stall_frontend), 32'(mode != MD_IDLE));
      checkOutput("m_halted", 32'(bus.halted), 32'(mode == MD_PARKED));
      checkOutput("m_redirect_pc", bus.redirect_pc, m_pc);
`ifdef SQUASH_CTRL_TIMEOUT_EN
      checkOutput("m_drain_timeout", 32'(bus.drain_timeout), 32'(m_timeout));
`endif
    end
  end

  task automatic applyStimulus(input logic sq, input logic [31:0] pc, input logic hl,
                               input logic [3:0] pend, input logic busy);
    bus.squash_in   = sq;
    bus.squash_pc   = pc;
    bus.halt_in     = hl;
    bus.sq_pending  = pend;
    bus.dcache_busy = busy;
    @(negedge clock);
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    bus.squash_in = 1'b0; bus.squash_pc = 32'd0; bus.halt_in = 1'b0;
    bus.sq_pending = 4'd0; bus.dcache_busy = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("rst_stall", 32'(bus.stall_frontend), 32'd0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 32'd0);
    checkOutput("rst_halted", 32'(bus.halted), 32'd0);
    #2 reset = 1'b0;

    // Basic squash: flush T+1, restore T+3..T+4, redirect T+5.
    applyStimulus(1'b1, 32'h100, 1'b0, 4'd0, 1'b0);
    checkOutput("basic_flush_t1", 32'(bus.flush_backend), 32'd1);
    checkOutput("basic_stall_t1", 32'(bus.stall_frontend), 32'd1);
    idle_cycle();
    checkOutput("basic_restore_t2", 32'(bus.rat_restore), 32'd0);
    idle_cycle();
    checkOutput("basic_restore_t3", 32'(bus.rat_restore), 32'd1);
    idle_cycle();
    checkOutput("basic_restore_t4", 32'(bus.rat_restore), 32'd1);
    idle_cycle();
    checkOutput("basic_redirect_t5", 32'(bus.redirect_valid), 32'd1);
    checkOutput("basic_pc_t5", bus.redirect_pc, 32'h100);
    checkOutput("basic_stall_t5", 32'(bus.stall_frontend), 32'd1);
    idle_cycle();
    checkOutput("basic_stall_t6", 32'(bus.stall_frontend), 32'd0);

    // Store drain: pending 3..0 over six cycles, dcache busy two more; RESTORE at T+10.
    applyStimulus(1'b1, 32'h240, 1'b0, 4'd3, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd3, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd3, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd2, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd2, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    checkOutput("drain_restore_t9", 32'(bus.rat_restore), 32'd0);
    idle_cycle();
    checkOutput("drain_restore_t10", 32'(bus.rat_restore), 32'd1);
    repeat (4) idle_cycle();

    // Squash beats halt; a squash during RESTORE is ignored.
    applyStimulus(1'b1, 32'h300, 1'b1, 4'd0, 1'b0);
    checkOutput("simul_flush", 32'(bus.flush_backend), 32'd1);
    idle_cycle();
    idle_cycle();
    checkOutput("simul_restore", 32'(bus.rat_restore), 32'd1);
    applyStimulus(1'b1, 32'h200, 1'b0, 4'd0, 1'b0);
    idle_cycle();
    checkOutput("simul_redirect", 32'(bus.redirect_valid), 32'd1);
    checkOutput("simul_pc", bus.redirect_pc, 32'h300);
    checkOutput("simul_halted", 32'(bus.halted), 32'd0);
    idle_cycle();
    checkOutput("simul_no_reflush", 32'(bus.flush_backend), 32'd0);

    // Reset during RESTORE drops every output immediately.
    applyStimulus(1'b1, 32'h400, 1'b0, 4'd0, 1'b0);
    idle_cycle();
    idle_cycle();
    checkOutput("rstmid_restore", 32'(bus.rat_restore), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstmid_restore_low", 32'(bus.rat_restore), 32'd0);
    checkOutput("rstmid_stall_low", 32'(bus.stall_frontend), 32'd0);
    checkOutput("rstmid_pc_zero", bus.redirect_pc, 32'd0);
    #1 reset = 1'b0;
    idle_cycle();
    checkOutput("rstmid_pc_after", bus.redirect_pc, 32'd0);

    // Halt with one pending store cleared after four cycles.
    applyStimulus(1'b0, 32'd0, 1'b1, 4'd1, 1'b0);
    checkOutput("halt_stall", 32'(bus.stall_frontend), 32'd1);
    repeat (4) applyStimulus(1'b0, 32'd0, 1'b0, 4'd1, 1'b0);
    checkOutput("halt_not_yet", 32'(bus.halted), 32'd0);
    idle_cycle();
    checkOutput("halt_parked", 32'(bus.halted), 32'd1);
    applyStimulus(1'b1, 32'h500, 1'b0, 4'd0, 1'b0);
    checkOutput("halt_ignore_squash", 32'(bus.flush_backend), 32'd0);
    checkOutput("halt_still", 32'(bus.halted), 32'd1);
    pulse_reset();

`ifdef SQUASH_CTRL_TIMEOUT_EN
    // Watchdog: dcache stays busy, DRAIN forced out after eight cycles.
    applyStimulus(1'b1, 32'h600, 1'b0, 4'd0, 1'b1);
    repeat (8) applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    checkOutput("wd_not_yet", 32'(bus.drain_timeout), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    checkOutput("wd_fired", 32'(bus.drain_timeout), 32'd1);
    checkOutput("wd_restore", 32'(bus.rat_restore), 32'd1);
    repeat (3) idle_cycle();
    checkOutput("wd_sticky", 32'(bus.drain_timeout), 32'd1);
    checkOutput("wd_idle", 32'(bus.stall_frontend), 32'd0);
    pulse_reset();
`endif

    // Randomized traffic; resets free a parked core.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] pend;
      if (mode == MD_PARKED || $urandom_range(0, 199) == 0) pulse_reset();
      pend = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      applyStimulus(1'($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 19) == 0),
                    pend, 1'($urandom_range(0, 3) == 0));
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
